// File: rtl/amp_control_fsm.sv
// amp_control_fsm: multicycle control unit for the amp RV32I core.
// Sequences the shared datapath through fetch/decode/execute/writeback,
// one datapath action per cycle, and decodes ALUControl and ImmSrc from
// the latched instruction fields.
//
// Optional feature: define AMP_ILLEGAL_TRAP_EN to add a TRAP state and the
// `illegal` output (unrecognised opcode or non-beq branch funct3 traps).
//
// Ports:
//   clk        core clock, rising edge
//   reset      asynchronous active-high; state -> FETCH, write enables held 0
//   op         Instr[6:0]
//   funct3     Instr[14:12]
//   funct7b5   Instr[30]
//   zero       ALU zero flag (used in BEQ only)
//   PCwrite    PC register enable
//   AdrSrc     memory address select (0 PC, 1 Result)
//   MemWrite   memory write enable
//   IRWrite    instruction/old-PC register enable
//   RegWrite   register file write enable
//   ResultSrc  00 ALUOut, 01 Data, 10 ALUResult
//   ALUSrcA    00 PC, 01 OldPC, 10 A
//   ALUSrcB    00 WriteData, 01 ImmExt, 10 constant 4
//   ImmSrc     00 I, 01 S, 10 B, 11 J
//   ALUControl ALU operation code
//   illegal    (AMP_ILLEGAL_TRAP_EN only) high while in TRAP
module amp_control_fsm (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       zero,
    output logic       PCwrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ImmSrc,
    output logic [3:0] ALUControl
`ifdef AMP_ILLEGAL_TRAP_EN
    ,
    output logic       illegal
`endif
);

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECR    = 4'd6,
        EXECI    = 4'd7,
        ALUWB    = 4'd8,
        JAL      = 4'd9,
        BEQ      = 4'd10
`ifdef AMP_ILLEGAL_TRAP_EN
        ,
        TRAP     = 4'd11
`endif
    } state_t;

    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_BEQ  = 7'b1100011;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_AND  = 4'b0010;
    localparam logic [3:0] ALU_OR   = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SLT  = 4'b0101;
    localparam logic [3:0] ALU_SLL  = 4'b0110;
    localparam logic [3:0] ALU_SRL  = 4'b0111;
    localparam logic [3:0] ALU_SRA  = 4'b1000;
    localparam logic [3:0] ALU_SLTU = 4'b1001;

    state_t state;
    state_t state_next;
    logic [3:0] funct_op;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= FETCH;
        else
            state <= state_next;
    end

    // funct3/funct7b5 decode shared by EXECR and EXECI; SUB only for R-type.
    always_comb begin
        funct_op = ALU_ADD;
        case (funct3)
            3'b000: funct_op = (state == EXECR && funct7b5) ? ALU_SUB : ALU_ADD;
            3'b001: funct_op = ALU_SLL;
            3'b010: funct_op = ALU_SLT;
            3'b011: funct_op = ALU_SLTU;
            3'b100: funct_op = ALU_XOR;
            3'b101: funct_op = funct7b5 ? ALU_SRA : ALU_SRL;
            3'b110: funct_op = ALU_OR;
            3'b111: funct_op = ALU_AND;
            default: funct_op = ALU_ADD;
        endcase
    end

    always_comb begin
        state_next = FETCH;
        PCwrite    = 1'b0;
        AdrSrc     = 1'b0;
        MemWrite   = 1'b0;
        IRWrite    = 1'b0;
        RegWrite   = 1'b0;
        ResultSrc  = 2'b00;
        ALUSrcA    = 2'b00;
        ALUSrcB    = 2'b00;
        ALUControl = ALU_ADD;
`ifdef AMP_ILLEGAL_TRAP_EN
        illegal    = 1'b0;
`endif

        case (state)
            FETCH: begin
                IRWrite    = 1'b1;
                ALUSrcB    = 2'b10;
                ResultSrc  = 2'b10;
                PCwrite    = 1'b1;
                state_next = DECODE;
            end
            DECODE: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
                case (op)
                    OP_LW, OP_SW: state_next = MEMADR;
                    OP_R:         state_next = EXECR;
                    OP_I:         state_next = EXECI;
                    OP_JAL:       state_next = JAL;
`ifdef AMP_ILLEGAL_TRAP_EN
                    OP_BEQ:       state_next = (funct3 == 3'b000) ? BEQ : TRAP;
                    default:      state_next = TRAP;
`else
                    OP_BEQ:       state_next = BEQ;
                    default:      state_next = FETCH;
`endif
                endcase
            end
            MEMADR: begin
                ALUSrcA    = 2'b10;
                ALUSrcB    = 2'b01;
                // Only lw/sw reach here; op[5] separates them.
                state_next = op[5] ? MEMWRITE : MEMREAD;
            end
            MEMREAD: begin
                AdrSrc     = 1'b1;
                state_next = MEMWB;
            end
            MEMWB: begin
                ResultSrc  = 2'b01;
                RegWrite   = 1'b1;
                state_next = FETCH;
            end
            MEMWRITE: begin
                AdrSrc     = 1'b1;
                MemWrite   = 1'b1;
                state_next = FETCH;
            end
            EXECR: begin
                ALUSrcA    = 2'b10;
                ALUControl = funct_op;
                state_next = ALUWB;
            end
            EXECI: begin
                ALUSrcA    = 2'b10;
                ALUSrcB    = 2'b01;
                ALUControl = funct_op;
                state_next = ALUWB;
            end
            ALUWB: begin
                RegWrite   = 1'b1;
                state_next = FETCH;
            end
            JAL: begin
                ALUSrcA    = 2'b01;
                ALUSrcB    = 2'b10;
                PCwrite    = 1'b1;
                state_next = ALUWB;
            end
            BEQ: begin
                ALUSrcA    = 2'b10;
                ALUControl = ALU_SUB;
                PCwrite    = zero;
                state_next = FETCH;
            end
`ifdef AMP_ILLEGAL_TRAP_EN
            TRAP: begin
                illegal    = 1'b1;
                state_next = TRAP;
            end
`endif
            default: state_next = FETCH;
        endcase

        // Reset already forces FETCH asynchronously; gating here keeps the
        // FETCH enables from appearing while reset is still high.
        if (reset) begin
            PCwrite  = 1'b0;
            IRWrite  = 1'b0;
            RegWrite = 1'b0;
            MemWrite = 1'b0;
        end
    end

    always_comb begin
        case (op)
            OP_SW:   ImmSrc = 2'b01;
            OP_BEQ:  ImmSrc = 2'b10;
            OP_JAL:  ImmSrc = 2'b11;
            default: ImmSrc = 2'b00;
        endcase
    end

endmodule

// File: tb/tb_amp_control_fsm.sv
// tb_amp_control_fsm: directed bench for amp_control_fsm. Walks lw, sw,
// R/I-type, jal, beq and an unknown opcode through the FSM, with a reset
// pulse mid-MEMREAD, comparing all outputs every cycle against hand-built
// expected vectors. Build with or without AMP_ILLEGAL_TRAP_EN.
module tb_amp_control_fsm;

    logic       clk = 1'b0;
    logic       reset;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       zero;
    logic       PCwrite, AdrSrc, MemWrite, IRWrite, RegWrite;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
    logic [3:0] ALUControl;
`ifdef AMP_ILLEGAL_TRAP_EN
    logic       illegal;
`endif

    int unsigned checks = 0;
    int unsigned errors = 0;

    amp_control_fsm dut (
        .clk        (clk),
        .reset      (reset),
        .op         (op),
        .funct3     (funct3),
        .funct7b5   (funct7b5),
        .zero       (zero),
        .PCwrite    (PCwrite),
        .AdrSrc     (AdrSrc),
        .MemWrite   (MemWrite),
        .IRWrite    (IRWrite),
        .RegWrite   (RegWrite),
        .ResultSrc  (ResultSrc),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .ImmSrc     (ImmSrc),
        .ALUControl (ALUControl)
`ifdef AMP_ILLEGAL_TRAP_EN
        ,
        .illegal    (illegal)
`endif
    );

    always #5 clk = ~clk;

    // {PCwrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc, SrcA, SrcB, ImmSrc, ALUControl}
    function automatic logic [16:0] ov(input logic pcw, input logic adr, input logic mw,
                                       input logic irw, input logic rw, input logic [1:0] rs,
                                       input logic [1:0] sa, input logic [1:0] sb,
                                       input logic [1:0] imm, input logic [3:0] alu);
        return {pcw, adr, mw, irw, rw, rs, sa, sb, imm, alu};
    endfunction

    logic [16:0] outs;
    assign outs = {PCwrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
                   ALUSrcA, ALUSrcB, ImmSrc, ALUControl};

    task automatic check(input string tag, input logic [16:0] got, input logic [16:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %05h expected %05h", tag, got, exp);
        end
    endtask

    // Check the current cycle, then advance to just after the next edge.
    task automatic cyc(input string tag, input logic [16:0] exp);
        #1;
        check(tag, outs, exp);
        @(posedge clk);
        #1;
    endtask

    task automatic set_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                             input logic z);
        op = o;
        funct3 = f3;
        funct7b5 = f7;
        zero = z;
    endtask

    function automatic logic [16:0] fetch_v(input logic [1:0] imm);
        return ov(1, 0, 0, 1, 0, 2'b10, 2'b00, 2'b10, imm, 4'b0000);
    endfunction
    function automatic logic [16:0] decode_v(input logic [1:0] imm);
        return ov(0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, imm, 4'b0000);
    endfunction
    function automatic logic [16:0] aluwb_v(input logic [1:0] imm);
        return ov(0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, imm, 4'b0000);
    endfunction

    initial begin
        #100000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1;
        set_instr(7'b0000011, 3'b010, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        // FETCH values with every write enable held low during reset
        check("reset_hold", outs, ov(0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 2'b00, 4'b0000));
`ifdef AMP_ILLEGAL_TRAP_EN
        check("reset_illegal", {16'b0, illegal}, 17'd0);
`endif
        @(negedge clk);
        reset = 1'b0;

        // lw, interrupted by reset in MEMREAD
        cyc("lw_fetch", fetch_v(2'b00));
        cyc("lw_decode", decode_v(2'b00));
        cyc("lw_memadr", ov(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b00, 4'b0000));
        #1;
        check("lw_memread", outs, ov(0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 4'b0000));
        reset = 1'b1;
        #1;
        check("rst_abort", outs, ov(0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 2'b00, 4'b0000));
        @(posedge clk);
        #1;
        check("rst_edge_hold", outs, ov(0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 2'b00, 4'b0000));
        @(negedge clk);
        reset = 1'b0;

        // full lw after release: first edge executes FETCH
        cyc("lw2_fetch", fetch_v(2'b00));
        cyc("lw2_decode", decode_v(2'b00));
        cyc("lw2_memadr", ov(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b00, 4'b0000));
        cyc("lw2_memread", ov(0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 4'b0000));
        cyc("lw2_memwb", ov(0, 0, 0, 0, 1, 2'b01, 2'b00, 2'b00, 2'b00, 4'b0000));

        // sw
        set_instr(7'b0100011, 3'b010, 1'b0, 1'b0);
        cyc("sw_fetch", fetch_v(2'b01));
        cyc("sw_decode", decode_v(2'b01));
        cyc("sw_memadr", ov(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b01, 4'b0000));
        cyc("sw_memwrite", ov(0, 1, 1, 0, 0, 2'b00, 2'b00, 2'b00, 2'b01, 4'b0000));

        // sub
        set_instr(7'b0110011, 3'b000, 1'b1, 1'b0);
        cyc("sub_fetch", fetch_v(2'b00));
        cyc("sub_decode", decode_v(2'b00));
        cyc("sub_execr", ov(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b00, 4'b0001));
        cyc("sub_aluwb", aluwb_v(2'b00));

        // and (R)
        set_instr(7'b0110011, 3'b111, 1'b0, 1'b0);
        cyc("and_fetch", fetch_v(2'b00));
        cyc("and_decode", decode_v(2'b00));
        cyc("and_execr", ov(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b00, 4'b0010));
        cyc("and_aluwb", aluwb_v(2'b00));

        // sra (R)
        set_instr(7'b0110011, 3'b101, 1'b1, 1'b0);
        cyc("sra_fetch", fetch_v(2'b00));
        cyc("sra_decode", decode_v(2'b00));
        cyc("sra_execr", ov(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b00, 4'b1000));
        cyc("sra_aluwb", aluwb_v(2'b00));

        // addi with funct7b5=1 stays ADD
        set_instr(7'b0010011, 3'b000, 1'b1, 1'b0);
        cyc("addi_fetch", fetch_v(2'b00));
        cyc("addi_decode", decode_v(2'b00));
        cyc("addi_execi", ov(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b00, 4'b0000));
        cyc("addi_aluwb", aluwb_v(2'b00));

        // I-type funct3 sweep, EXECI cycle only checked in detail
        for (int i = 0; i < 7; i++) begin
            logic [2:0] f3;
            logic       f7;
            logic [3:0] exp_alu;
            case (i)
                0: begin f3 = 3'b101; f7 = 1'b1; exp_alu = 4'b1000; end
                1: begin f3 = 3'b101; f7 = 1'b0; exp_alu = 4'b0111; end
                2: begin f3 = 3'b010; f7 = 1'b0; exp_alu = 4'b0101; end
                3: begin f3 = 3'b011; f7 = 1'b0; exp_alu = 4'b1001; end
                4: begin f3 = 3'b100; f7 = 1'b0; exp_alu = 4'b0100; end
                5: begin f3 = 3'b110; f7 = 1'b0; exp_alu = 4'b0011; end
                default: begin f3 = 3'b001; f7 = 1'b0; exp_alu = 4'b0110; end
            endcase
            set_instr(7'b0010011, f3, f7, 1'b0);
            cyc($sformatf("itype%0d_fetch", i), fetch_v(2'b00));
            cyc($sformatf("itype%0d_decode", i), decode_v(2'b00));
            cyc($sformatf("itype%0d_execi", i),
                ov(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b00, exp_alu));
            cyc($sformatf("itype%0d_aluwb", i), aluwb_v(2'b00));
        end

        // jal
        set_instr(7'b1101111, 3'b000, 1'b0, 1'b0);
        cyc("jal_fetch", fetch_v(2'b11));
        cyc("jal_decode", decode_v(2'b11));
        cyc("jal_jal", ov(1, 0, 0, 0, 0, 2'b00, 2'b01, 2'b10, 2'b11, 4'b0000));
        cyc("jal_aluwb", aluwb_v(2'b11));

        // beq taken (zero high through the whole instruction)
        set_instr(7'b1100011, 3'b000, 1'b0, 1'b1);
        cyc("beqt_fetch", fetch_v(2'b10));
        cyc("beqt_decode", decode_v(2'b10));
        cyc("beqt_beq", ov(1, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b10, 4'b0001));

        // beq not taken
        set_instr(7'b1100011, 3'b000, 1'b0, 1'b0);
        cyc("beqn_fetch", fetch_v(2'b10));
        cyc("beqn_decode", decode_v(2'b10));
        cyc("beqn_beq", ov(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b10, 4'b0001));

`ifndef AMP_ILLEGAL_TRAP_EN
        // bne encoding executes as beq when traps are disabled
        set_instr(7'b1100011, 3'b001, 1'b0, 1'b1);
        cyc("bne_fetch", fetch_v(2'b10));
        cyc("bne_decode", decode_v(2'b10));
        cyc("bne_beq", ov(1, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b10, 4'b0001));
`endif

        // unknown opcode
        set_instr(7'b1111111, 3'b000, 1'b0, 1'b0);
        cyc("ill_fetch", fetch_v(2'b00));
        cyc("ill_decode", decode_v(2'b00));
`ifdef AMP_ILLEGAL_TRAP_EN
        for (int i = 0; i < 3; i++) begin
            #1;
            check($sformatf("trap%0d_outs", i), outs,
                  ov(0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 4'b0000));
            check($sformatf("trap%0d_illegal", i), {16'b0, illegal}, 17'd1);
            @(posedge clk);
            #1;
        end
        reset = 1'b1;
        #1;
        check("trap_reset_illegal", {16'b0, illegal}, 17'd0);
        @(negedge clk);
        reset = 1'b0;
        set_instr(7'b0010011, 3'b000, 1'b0, 1'b0);
        cyc("post_trap_fetch", fetch_v(2'b00));
        cyc("post_trap_decode", decode_v(2'b00));
`else
        cyc("ill_back_fetch", fetch_v(2'b00));
        cyc("ill_back_decode", decode_v(2'b00));
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
